vector_writeback_stage: RTL and testbench

//  Vector write-back stage: accepts execute results (vd address, data, mask info) over a valid/ready handshake.

---
 rtl/vector_writeback_stage_pkg.sv | 30 +++
 rtl/vector_wb_fifo.sv | 85 ++++++++
 rtl/vector_writeback_stage.sv | 159 +++++++++++++++
 tb/tb_vector_writeback_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_writeback_stage_pkg.sv
// -----------------------------------------------------------------------------
// vector_writeback_stage_pkg
// Shared definitions for the vector write-back stage:
//   - default geometry of the vector register file
//   - bit index of the vd_write flag inside the register vector
//   - element-count derivation used to size the vl port and the merge loop
//   - output register state encoding
// Optional feature macro used by the top: VWB_MASK_MERGE_EN
// -----------------------------------------------------------------------------
package vector_writeback_stage_pkg;

  localparam int unsigned VWB_VRF_WIDTH     = 128;
  localparam int unsigned VWB_VRF_DEPTH     = 32;
  localparam int unsigned VWB_ELEMENT_WIDTH = 32;
  localparam int unsigned VWB_FIFO_DEPTH    = 2;

  // Position of the vd_write bit in the decode/register-vector bundle.
  localparam int unsigned REGVEC_VD_WRITE_BIT = 0;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_e;

  function automatic int unsigned vwb_num_elements(input int unsigned vrf_width,
                                                   input int unsigned element_width);
    return vrf_width / element_width;
  endfunction

endpackage

// File: rtl/vector_wb_fifo.sv
// -----------------------------------------------------------------------------
// vector_wb_fifo
// Generic DEPTH-entry in-order buffer. Each entry carries a tag (visible for
// every entry, used by the parent for hazard decode) and a payload (visible
// only at the head). Per-entry valid bits track EMPTY/PENDING state.
// Ports:
//   clk_i, rstn_i       clock, async active-low reset
//   push_i, tag_i, data_i   write a new entry at the tail (ignored when full)
//   pop_i               retire the head entry (ignored when empty)
//   head_tag_o/head_data_o  contents of the oldest entry
//   valid_o             per-entry valid bits
//   tags_o              per-entry tags
//   full_o, empty_o     occupancy flags derived from the entry count
// -----------------------------------------------------------------------------
module vector_wb_fifo #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned TAG_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 push_i,
  input  logic [TAG_WIDTH-1:0]                 tag_i,
  input  logic [DATA_WIDTH-1:0]                data_i,
  input  logic                                 pop_i,
  output logic [TAG_WIDTH-1:0]                 head_tag_o,
  output logic [DATA_WIDTH-1:0]                head_data_o,
  output logic [DEPTH-1:0]                     valid_o,
  output logic [DEPTH-1:0][TAG_WIDTH-1:0]      tags_o,
  output logic                                 full_o,
  output logic                                 empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][TAG_WIDTH-1:0]  tag_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
  logic [DEPTH-1:0]                 valid_q;
  logic [PTR_W-1:0]                 wr_ptr_q;
  logic [PTR_W-1:0]                 rd_ptr_q;
  logic [PTR_W:0]                   count_q;

  logic push_ok;
  logic pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
  // increment wraps modulo DEPTH on its own.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tag_q    <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        tag_q[wr_ptr_q]   <= tag_i;
        data_q[wr_ptr_q]  <= data_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_tag_o  = tag_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign valid_o     = valid_q;
  assign tags_o      = tag_q;

endmodule

// File: rtl/vector_writeback_stage.sv
// -----------------------------------------------------------------------------
// vector_writeback_stage
// Accepts execute results over valid/ready, buffers them in vector_wb_fifo and
// retires one entry per cycle into the VRF synchronous write port through a
// registered IDLE/WRITE output stage. Exports a per-register pending vector so
// decode can stall RAW hazards.
// Ports:
//   clk_i, rstn_i                  clock, async active-low reset
//   ex_valid_i / ex_ready_o        execute result handshake (ready = not full)
//   ex_vd_address_i, ex_data_i     destination register and result
//   ex_old_vd_i, ex_vmask_i,
//   ex_masked_i, ex_vl_i           merge inputs (only used with the macro)
//   wb_stall_i                     VRF write port busy, hold the head
//   vd_write_enable_o/_address_o/_data_o  registered VRF write port
//   pending_o                      bit r set while a write to vr is in flight
//   empty_o                        no buffered writes
// Configuration macro: VWB_MASK_MERGE_EN
//   defined   : inactive/tail elements keep ex_old_vd_i, merged at push time
//   undefined : ex_data_i is written unmodified
//
// Output register states:
//   state    | meaning
//   WB_IDLE  | no VRF write presented this cycle
//   WB_WRITE | vd_write_* valid; VRF commits at the next edge
// -----------------------------------------------------------------------------
module vector_writeback_stage
  import vector_writeback_stage_pkg::*;
#(
  parameter  int unsigned VRF_WIDTH         = VWB_VRF_WIDTH,
  parameter  int unsigned VRF_DEPTH         = VWB_VRF_DEPTH,
  parameter  int unsigned VRF_ADDRESS_WIDTH = $clog2(VRF_DEPTH),
  parameter  int unsigned ELEMENT_WIDTH     = VWB_ELEMENT_WIDTH,
  parameter  int unsigned FIFO_DEPTH        = VWB_FIFO_DEPTH,
  localparam int unsigned NUM_ELEMENTS      = vwb_num_elements(VRF_WIDTH, ELEMENT_WIDTH),
  localparam int unsigned VL_WIDTH          = $clog2(NUM_ELEMENTS) + 1
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         ex_valid_i,
  output logic                         ex_ready_o,
  input  logic [VRF_ADDRESS_WIDTH-1:0] ex_vd_address_i,
  input  logic [VRF_WIDTH-1:0]         ex_data_i,
  input  logic [VRF_WIDTH-1:0]         ex_old_vd_i,
  input  logic [VRF_WIDTH-1:0]         ex_vmask_i,
  input  logic                         ex_masked_i,
  input  logic [VL_WIDTH-1:0]          ex_vl_i,
  input  logic                         wb_stall_i,
  output logic                         vd_write_enable_o,
  output logic [VRF_ADDRESS_WIDTH-1:0] vd_write_address_o,
  output logic [VRF_WIDTH-1:0]         vd_write_data_o,
  output logic [VRF_DEPTH-1:0]         pending_o,
  output logic                         empty_o
);

  logic                                         push;
  logic                                         pop;
  logic [VRF_WIDTH-1:0]                         push_data;
  logic [VRF_ADDRESS_WIDTH-1:0]                 head_addr;
  logic [VRF_WIDTH-1:0]                         head_data;
  logic [FIFO_DEPTH-1:0]                        fifo_valid;
  logic [FIFO_DEPTH-1:0][VRF_ADDRESS_WIDTH-1:0] fifo_addr;
  logic                                         fifo_full;
  logic                                         fifo_empty;

  wb_state_e                    state_q;
  logic [VRF_ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [VRF_WIDTH-1:0]         wr_data_q;

  // ---------------------------------------------------------------------------
  // Push-time merge: the buffer stores the final register image so the write
  // port never needs the mask inputs again.
  // ---------------------------------------------------------------------------
`ifdef VWB_MASK_MERGE_EN
  always_comb begin
    push_data = ex_old_vd_i;
    for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
      if ((i < int'(ex_vl_i)) && (!ex_masked_i || ex_vmask_i[i])) begin
        push_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = ex_data_i[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      end
    end
  end

  // Only the low NUM_ELEMENTS bits of v0 act as element mask bits.
  logic unused_vmask_hi;
  assign unused_vmask_hi = ^ex_vmask_i[VRF_WIDTH-1:NUM_ELEMENTS];
`else
  assign push_data = ex_data_i;

  logic unused_merge_inputs;
  assign unused_merge_inputs = ^{ex_old_vd_i, ex_vmask_i, ex_masked_i, ex_vl_i};
`endif

  assign ex_ready_o = ~fifo_full;
  assign push       = ex_valid_i & ex_ready_o;
  // A non-empty FIFO always has a valid head; an empty one has nothing to pop,
  // so a push into an empty buffer retires no earlier than the next cycle.
  assign pop        = ~fifo_empty & ~wb_stall_i;

  vector_wb_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .TAG_WIDTH  (VRF_ADDRESS_WIDTH),
    .DATA_WIDTH (VRF_WIDTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (push),
    .tag_i       (ex_vd_address_i),
    .data_i      (push_data),
    .pop_i       (pop),
    .head_tag_o  (head_addr),
    .head_data_o (head_data),
    .valid_o     (fifo_valid),
    .tags_o      (fifo_addr),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Registered VRF write port. Each pop presents exactly one WRITE cycle;
  // a stall or an empty buffer returns the port to IDLE on the next edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= WB_IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (pop) begin
      state_q   <= WB_WRITE;
      wr_addr_q <= head_addr;
      wr_data_q <= head_data;
    end else begin
      state_q   <= WB_IDLE;
    end
  end

  assign vd_write_enable_o  = (state_q == WB_WRITE);
  assign vd_write_address_o = wr_addr_q;
  assign vd_write_data_o    = wr_data_q;

  // ---------------------------------------------------------------------------
  // Pending decode: buffered entries plus the write currently presented. An
  // entry moves from the FIFO into the output register on the same edge, so a
  // bit stays set continuously until the cycle after its last write.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_o = '0;
    for (int e = 0; e < int'(FIFO_DEPTH); e++) begin
      if (fifo_valid[e]) begin
        pending_o[fifo_addr[e]] = 1'b1;
      end
    end
    if (state_q == WB_WRITE) begin
      pending_o[wr_addr_q] = 1'b1;
    end
  end

  assign empty_o = fifo_empty;

endmodule

// File: tb/tb_vector_writeback_stage.sv
module tb_vector_writeback_stage;

  localparam int VW = 128;
  localparam int AW = 5;
  localparam int VD = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [VW-1:0] data;
    logic [VW-1:0] old;
    logic [VW-1:0] vmask;
    logic          masked;
    logic [2:0]    vl;
    logic [VW-1:0] exp_merge;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [VW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ex_valid_i;
  logic          ex_ready_o;
  logic [AW-1:0] ex_vd_address_i;
  logic [VW-1:0] ex_data_i;
  logic [VW-1:0] ex_old_vd_i;
  logic [VW-1:0] ex_vmask_i;
  logic          ex_masked_i;
  logic [2:0]    ex_vl_i;
  logic          wb_stall_i;
  logic          vd_write_enable_o;
  logic [AW-1:0] vd_write_address_o;
  logic [VW-1:0] vd_write_data_o;
  logic [VD-1:0] pending_o;
  logic          empty_o;

  vector_writeback_stage dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .ex_valid_i         (ex_valid_i),
    .ex_ready_o         (ex_ready_o),
    .ex_vd_address_i    (ex_vd_address_i),
    .ex_data_i          (ex_data_i),
    .ex_old_vd_i        (ex_old_vd_i),
    .ex_vmask_i         (ex_vmask_i),
    .ex_masked_i        (ex_masked_i),
    .ex_vl_i            (ex_vl_i),
    .wb_stall_i         (wb_stall_i),
    .vd_write_enable_o  (vd_write_enable_o),
    .vd_write_address_o (vd_write_address_o),
    .vd_write_data_o    (vd_write_data_o),
    .pending_o          (pending_o),
    .empty_o            (empty_o)
  );

  always #5 clk = ~clk;

  int            total  = 0;
  int            bad    = 0;
  int            writes = 0;
  exp_t          sb[$];
  exp_t          cur_exp;
  logic [VW-1:0] vrf [VD];
  vec_t          vecs [6];

  localparam logic [VW-1:0] D = 128'h44444444_33333333_22222222_11111111;
  localparam logic [VW-1:0] O = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_write();
    exp_t e;
    if (vd_write_enable_o === 1'b1) begin
      writes++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d expected no write", vd_write_address_o);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", VW'(vd_write_address_o), VW'(e.addr));
        chk("wr_data", vd_write_data_o, e.data);
        vrf[vd_write_address_o] = vd_write_data_o;
      end
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; ready depends only on
  // state registers, so acceptance is decided before the edge.
  task automatic cycle();
    logic acc;
    acc = ex_valid_i && ex_ready_o;
    @(posedge clk);
    #1;
    if (acc) sb.push_back(cur_exp);
    check_write();
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [VW-1:0] d, input logic [VW-1:0] o,
                       input logic [VW-1:0] m, input logic msk, input logic [2:0] vl,
                       input logic [VW-1:0] exp_data);
    ex_valid_i      = 1'b1;
    ex_vd_address_i = a;
    ex_data_i       = d;
    ex_old_vd_i     = o;
    ex_vmask_i      = m;
    ex_masked_i     = msk;
    ex_vl_i         = vl;
    cur_exp.addr    = a;
    cur_exp.data    = exp_data;
  endtask

  task automatic drive_vec(input vec_t v);
`ifdef VWB_MASK_MERGE_EN
    drive(v.addr, v.data, v.old, v.vmask, v.masked, v.vl, v.exp_merge);
`else
    drive(v.addr, v.data, v.old, v.vmask, v.masked, v.vl, v.data);
`endif
  endtask

  task automatic drain();
    ex_valid_i = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
    chk("drain_left", VW'(sb.size()), '0);
    cycle();
    chk("drain_en", VW'(vd_write_enable_o), '0);
    chk("drain_empty", VW'(empty_o), VW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    vecs[0] = '{5'd7,  {4{32'hFFFFFFFF}}, '0, 128'h5, 1'b1, 3'd3,
                128'h00000000_FFFFFFFF_00000000_FFFFFFFF};
    vecs[1] = '{5'd9,  D, O, '0,     1'b0, 3'd4, D};
    vecs[2] = '{5'd10, D, O, '0,     1'b0, 3'd2, 128'hAAAAAAAA_BBBBBBBB_22222222_11111111};
    vecs[3] = '{5'd31, D, O, 128'hA, 1'b1, 3'd4, 128'h44444444_BBBBBBBB_22222222_DDDDDDDD};
    vecs[4] = '{5'd0,  D, O, 128'hF, 1'b1, 3'd0, O};
    vecs[5] = '{5'd12, D, O, 128'h4, 1'b1, 3'd3, 128'hAAAAAAAA_33333333_CCCCCCCC_DDDDDDDD};

    for (int r = 0; r < VD; r++) vrf[r] = '0;
    rstn = 1'b0;
    ex_valid_i = 1'b0; ex_vd_address_i = '0; ex_data_i = '0; ex_old_vd_i = '0;
    ex_vmask_i = '0; ex_masked_i = 1'b0; ex_vl_i = '0; wb_stall_i = 1'b0;
    cur_exp.addr = '0; cur_exp.data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", VW'(ex_ready_o), VW'(1));
    chk("rst_en", VW'(vd_write_enable_o), '0);
    chk("rst_pending", VW'(pending_o), '0);
    chk("rst_empty", VW'(empty_o), VW'(1));
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single write: visible two edges after acceptance
    w0 = writes;
    drive(5'd5, {4{32'hA5A5A5A5}}, '0, '0, 1'b0, 3'd4, {4{32'hA5A5A5A5}});
    cycle();
    ex_valid_i = 1'b0;
    chk("single_pend_buf", VW'(pending_o[5]), VW'(1));
    chk("single_en_early", VW'(vd_write_enable_o), '0);
    chk("single_not_empty", VW'(empty_o), '0);
    cycle();
    chk("single_en", VW'(vd_write_enable_o), VW'(1));
    chk("single_pend_wr", VW'(pending_o[5]), VW'(1));
    cycle();
    chk("single_en_drop", VW'(vd_write_enable_o), '0);
    chk("single_pend_clr", VW'(pending_o), '0);
    chk("single_vrf", vrf[5], {4{32'hA5A5A5A5}});
    chk("single_count", VW'(writes - w0), VW'(1));

    // Backpressure
    wb_stall_i = 1'b1;
    drive(5'd1, {4{32'h11111111}}, '0, '0, 1'b0, 3'd4, {4{32'h11111111}});
    cycle();
    drive(5'd2, {4{32'h22222222}}, '0, '0, 1'b0, 3'd4, {4{32'h22222222}});
    cycle();
    chk("bp_ready_full", VW'(ex_ready_o), '0);
    drive(5'd4, {4{32'h44444444}}, '0, '0, 1'b0, 3'd4, {4{32'h44444444}});
    cycle();
    chk("bp_ready_held", VW'(ex_ready_o), '0);
    chk("bp_no_write", VW'(vd_write_enable_o), '0);
    chk("bp_pending", VW'(pending_o), VW'(32'h6));
    chk("bp_sb_size", VW'(sb.size()), VW'(2));
    wb_stall_i = 1'b0;
    cycle();
    chk("bp_rel_w1", VW'(vd_write_enable_o), VW'(1));
    cycle();
    chk("bp_rel_w2", VW'(vd_write_enable_o), VW'(1));
    drain();
    chk("bp_vrf4", vrf[4], {4{32'h44444444}});

    // Same-register ordering
    drive(5'd3, 128'd1, '0, '0, 1'b0, 3'd4, 128'd1);
    cycle();
    drive(5'd3, 128'd2, '0, '0, 1'b0, 3'd4, 128'd2);
    cycle();
    ex_valid_i = 1'b0;
    chk("ord_pend_a", VW'(pending_o[3]), VW'(1));
    cycle();
    chk("ord_pend_b", VW'(pending_o[3]), VW'(1));
    chk("ord_vrf_mid", vrf[3], 128'd2);
    cycle();
    chk("ord_pend_clr", VW'(pending_o[3]), '0);
    chk("ord_vrf", vrf[3], 128'd2);

    // Table vectors back-to-back: merge cases and full throughput
    w0 = writes;
    for (int i = 0; i < 6; i++) begin
      chk("tput_ready", VW'(ex_ready_o), VW'(1));
      drive_vec(vecs[i]);
      cycle();
      if (i > 0) chk("tput_en", VW'(vd_write_enable_o), VW'(1));
    end
    drain();
    chk("tput_count", VW'(writes - w0), VW'(6));

    // Reset while a write is presented and another is buffered
    drive(5'd8, {4{32'h88888888}}, '0, '0, 1'b0, 3'd4, {4{32'h88888888}});
    cycle();
    drive(5'd9, {4{32'h99999999}}, '0, '0, 1'b0, 3'd4, {4{32'h99999999}});
    cycle();
    ex_valid_i = 1'b0;
    chk("mid_en_before", VW'(vd_write_enable_o), VW'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_en", VW'(vd_write_enable_o), '0);
    chk("mid_rst_pending", VW'(pending_o), '0);
    chk("mid_rst_ready", VW'(ex_ready_o), VW'(1));
    chk("mid_rst_empty", VW'(empty_o), VW'(1));
    sb.delete();
    w0 = writes;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) cycle();
    chk("mid_no_writes", VW'(writes - w0), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
